// File: rtl/uart_fifo_core.sv
// UART core: shared 16x baud tick, FIFO-buffered transmitter and receiver with
// runtime parity/stop configuration and per-word RX error flags.
module uart_fifo_core #(
    parameter int  DATABITS   = 8,
    parameter int  FIFO_DEPTH = 16,
    parameter int  DIV_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_W-1:0]    baud_div,
    input  logic                cfg_parity_en,
    input  logic                cfg_parity_odd,
    input  logic                cfg_stop2,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DATABITS-1:0] tx_data_in,
    output logic                tx_data,
    output logic                tx_busy,
    output logic [LVL_W-1:0]    tx_level,
    input  logic                rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [DATABITS-1:0] rx_data_out,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    output logic [LVL_W-1:0]    rx_level,
    output logic                rx_overrun,
    input  logic                rx_overrun_clr,
    output logic                baud_tick_16x_dbg
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int RXW = DATABITS + 2;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick              = (div_cnt == baud_div);
    assign baud_tick_16x_dbg = tick;

    // A counter left above a freshly lowered divisor wraps on the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 div_cnt <= '0;
        else if (div_cnt >= baud_div) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- TX FIFO ----------------
    logic [DATABITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]       tx_wp, tx_rp;
    logic [LVL_W-1:0]    tx_cnt;
    logic                tx_push, tx_pop, tx_empty, tx_frame_end;

    state_e              tx_state;
    logic [3:0]          tx_sub, tx_bit;
    logic [DATABITS-1:0] tx_shift;
    logic                tx_par_en, tx_par_bit, tx_stop2, tx_q;

    assign tx_ready     = (tx_cnt != LVL_W'(FIFO_DEPTH));
    assign tx_empty     = (tx_cnt == '0);
    assign tx_level     = tx_cnt;
    assign tx_push      = tx_valid && tx_ready;
    assign tx_frame_end = (tx_state == StStop) && tick && (tx_sub == 4'd15) &&
                          (tx_bit == 4'(tx_stop2));
    assign tx_pop       = !tx_empty && ((tx_state == StIdle) || tx_frame_end);
    assign tx_data      = tx_q;
    assign tx_busy      = !tx_empty || (tx_state != StIdle);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + LVL_W'(tx_push) - LVL_W'(tx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= StIdle;
            tx_sub     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
            tx_q       <= 1'b1;
        end else if (tx_pop) begin
            tx_state   <= StStart;
            tx_sub     <= '0;
            tx_bit     <= '0;
            tx_shift   <= tx_mem[tx_rp];
            tx_par_en  <= cfg_parity_en;
            tx_par_bit <= (^tx_mem[tx_rp]) ^ cfg_parity_odd;
            tx_stop2   <= cfg_stop2;
            tx_q       <= 1'b0;
        end else if (tx_state != StIdle && tick) begin
            tx_sub <= tx_sub + 1'b1;
            if (tx_sub == 4'd15) begin
                case (tx_state)
                    StStart: begin
                        tx_state <= StData;
                        tx_bit   <= '0;
                        tx_q     <= tx_shift[0];
                    end
                    StData: begin
                        if (tx_bit == 4'(DATABITS - 1)) begin
                            tx_bit <= '0;
                            if (tx_par_en) begin
                                tx_state <= StParity;
                                tx_q     <= tx_par_bit;
                            end else begin
                                tx_state <= StStop;
                                tx_q     <= 1'b1;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx_q     <= tx_shift[1];
                        end
                    end
                    StParity: begin
                        tx_state <= StStop;
                        tx_bit   <= '0;
                        tx_q     <= 1'b1;
                    end
                    StStop: begin
                        if (tx_bit == 4'(tx_stop2)) tx_state <= StIdle;
                        else                        tx_bit   <= tx_bit + 1'b1;
                    end
                    default: tx_state <= StIdle;
                endcase
            end
        end
    end

    // ---------------- RX FSM ----------------
    logic [1:0]          rx_sync;
    logic                rx_s, rx_prev, rx_wait_high;
    state_e              rx_state;
    logic [3:0]          rx_sub, rx_bit;
    logic [DATABITS-1:0] rx_shift;
    logic                rx_par_en, rx_par_odd, rx_stop2, rx_perr, rx_ferr;
    logic                rx_bit_end, rx_push;
    logic [RXW-1:0]      rx_wdata;

    assign rx_s       = rx_sync[1];
    assign rx_bit_end = tick && (rx_sub == 4'd15);
    assign rx_push    = (rx_state == StStop) && rx_bit_end && (rx_bit == 4'(rx_stop2));
    assign rx_wdata   = {rx_ferr | !rx_s, rx_perr, rx_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync      <= 2'b11;
            rx_prev      <= 1'b1;
            rx_wait_high <= 1'b0;
            rx_state     <= StIdle;
            rx_sub       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par_en    <= 1'b0;
            rx_par_odd   <= 1'b0;
            rx_stop2     <= 1'b0;
            rx_perr      <= 1'b0;
            rx_ferr      <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx_data};
            rx_prev <= rx_s;
            case (rx_state)
                StIdle: begin
                    // After a framing error the line must return high before re-arming.
                    if (rx_wait_high) begin
                        if (rx_s) rx_wait_high <= 1'b0;
                    end else if (rx_prev && !rx_s) begin
                        rx_state <= StStart;
                        rx_sub   <= '0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (rx_sub == 4'd7) begin
                            if (!rx_s) begin
                                rx_state   <= StData;
                                rx_sub     <= '0;
                                rx_bit     <= '0;
                                rx_par_en  <= cfg_parity_en;
                                rx_par_odd <= cfg_parity_odd;
                                rx_stop2   <= cfg_stop2;
                                rx_perr    <= 1'b0;
                                rx_ferr    <= 1'b0;
                            end else begin
                                rx_state <= StIdle;
                            end
                        end else begin
                            rx_sub <= rx_sub + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (tick) rx_sub <= rx_sub + 1'b1;
                    if (rx_bit_end) begin
                        rx_shift <= {rx_s, rx_shift[DATABITS-1:1]};
                        if (rx_bit == 4'(DATABITS - 1)) begin
                            rx_bit   <= '0;
                            rx_state <= rx_par_en ? StParity : StStop;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (tick) rx_sub <= rx_sub + 1'b1;
                    if (rx_bit_end) begin
                        rx_perr  <= rx_s ^ (^rx_shift) ^ rx_par_odd;
                        rx_state <= StStop;
                        rx_bit   <= '0;
                    end
                end
                StStop: begin
                    if (tick) rx_sub <= rx_sub + 1'b1;
                    if (rx_bit_end) begin
                        if (!rx_s) rx_ferr <= 1'b1;
                        if (rx_push) begin
                            rx_state     <= StIdle;
                            rx_wait_high <= rx_ferr | !rx_s;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                default: rx_state <= StIdle;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [RXW-1:0]   rx_mem [FIFO_DEPTH];
    logic [PW-1:0]    rx_wp, rx_rp;
    logic [LVL_W-1:0] rx_cnt;
    logic             rx_full, rx_wr, rx_pop;
    logic [RXW-1:0]   rx_head;

    assign rx_full       = (rx_cnt == LVL_W'(FIFO_DEPTH));
    assign rx_wr         = rx_push && !rx_full;
    assign rx_valid      = (rx_cnt != '0);
    assign rx_pop        = rx_valid && rx_ready;
    assign rx_level      = rx_cnt;
    assign rx_head       = rx_mem[rx_rp];
    assign rx_data_out   = rx_valid ? rx_head[DATABITS-1:0] : '0;
    assign rx_parity_err = rx_valid && rx_head[DATABITS];
    assign rx_frame_err  = rx_valid && rx_head[DATABITS+1];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp] <= rx_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wp      <= '0;
            rx_rp      <= '0;
            rx_cnt     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_wr)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + LVL_W'(rx_wr) - LVL_W'(rx_pop);
            // Fullness is judged before the same-cycle pop; clear beats set.
            if (rx_overrun_clr)        rx_overrun <= 1'b0;
            else if (rx_push && rx_full) rx_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: loopback, burst, error, overrun, glitch and reset cases.
module tb_uart_fifo_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic        tx_valid, tx_ready, tx_data, tx_busy;
    logic [7:0]  tx_data_in;
    logic [4:0]  tx_level, rx_level;
    logic        rx_line, rx_drv, loop_en;
    logic        rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun, rx_overrun_clr;
    logic [7:0]  rx_data_out;
    logic        tick_dbg;

    int vectors = 0;
    int miscompares = 0;

    assign rx_line = loop_en ? tx_data : rx_drv;

    uart_fifo_core dut (
        .clk               (clk),
        .reset             (reset),
        .baud_div          (baud_div),
        .cfg_parity_en     (cfg_parity_en),
        .cfg_parity_odd    (cfg_parity_odd),
        .cfg_stop2         (cfg_stop2),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_data_in        (tx_data_in),
        .tx_data           (tx_data),
        .tx_busy           (tx_busy),
        .tx_level          (tx_level),
        .rx_data           (rx_line),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .rx_data_out       (rx_data_out),
        .rx_parity_err     (rx_parity_err),
        .rx_frame_err      (rx_frame_err),
        .rx_level          (rx_level),
        .rx_overrun        (rx_overrun),
        .rx_overrun_clr    (rx_overrun_clr),
        .baud_tick_16x_dbg (tick_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Serial line value of bit idx in a frame (0 = start), from the frame rules.
    function automatic logic frame_bit(input logic [7:0] w, input int idx, input logic pen,
                                       input logic podd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (idx == 9 && pen) return (($countones(w) % 2) != 0) ^ podd;
        return 1'b1;
    endfunction

    task automatic drive_frame(input logic [7:0] w, input logic pen, input logic podd,
                               input logic stop2, input logic flip, input int bitcyc);
        int len;
        logic b;
        len = 10 + int'(pen) + int'(stop2);
        for (int idx = 0; idx < len; idx++) begin
            b = frame_bit(w, idx, pen, podd);
            if (flip && pen && idx == 9) b = ~b;
            rx_drv = b;
            repeat (bitcyc) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic push_tx(input logic [7:0] w);
        tx_valid   = 1'b1;
        tx_data_in = w;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int budget);
        int n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rx_wait", rx_valid, 1);
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_wait", tx_busy, 0);
    endtask

    task automatic pop_rx;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] got[$];
        logic [7:0] expq[$];
        int n, len, cyc, t_fall, t_idle, cnt;
        logic [7:0] bd;
        logic bf;

        reset = 1'b0; baud_div = 16'd3;
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        tx_valid = 1'b0; tx_data_in = '0; rx_drv = 1'b1; loop_en = 1'b1;
        rx_ready = 1'b0; rx_overrun_clr = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_data", tx_data, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data_out", rx_data_out, 0);
        check("rst_rx_perr", rx_parity_err, 0);
        check("rst_rx_ferr", rx_frame_err, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        check("rst_tick", tick_dbg, 0);
        reset = 1'b1;
        @(negedge clk);

        // Loopback 8E1 at baud_div=3: 64 cycles per bit.
        push_tx(8'hA5);
        n = 0;
        while (tx_data && n < 200) begin @(negedge clk); n++; end
        check("lb_start_seen", tx_data, 0);
        len = 0;
        while (!tx_data && len < 100) begin len++; @(negedge clk); end
        check_range("lb_start_len", len, 61, 64);
        for (int b = 1; b <= 10; b++) begin
            check($sformatf("lb_bit%0d_first", b), tx_data, frame_bit(8'hA5, b, 1'b1, 1'b0));
            repeat (63) @(negedge clk);
            check($sformatf("lb_bit%0d_last", b), tx_data, frame_bit(8'hA5, b, 1'b1, 1'b0));
            @(negedge clk);
        end
        wait_rx(200);
        check("lb_rx_data", rx_data_out, 8'hA5);
        check("lb_rx_perr", rx_parity_err, 0);
        check("lb_rx_ferr", rx_frame_err, 0);
        pop_rx();
        check("lb_rx_empty", rx_valid, 0);
        check("lb_rx_forced0", rx_data_out, 0);

        // Random loopback words and configurations.
        baud_div = 16'd1;
        for (int i = 0; i < 6; i++) begin
            wait_tx_idle(1000);
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_stop2      = 1'($urandom);
            w = 8'($urandom);
            push_tx(w);
            wait_rx(1000);
            check($sformatf("rnd%0d_data", i), rx_data_out, w);
            check($sformatf("rnd%0d_perr", i), rx_parity_err, 0);
            check($sformatf("rnd%0d_ferr", i), rx_frame_err, 0);
            pop_rx();
        end
        wait_tx_idle(1000);
        repeat (40) @(negedge clk);

        // Burst 8N2: 17 back-to-back pushes (first is popped at once), contiguous frames.
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        rx_ready = 1'b1; tx_valid = 1'b1; tx_data_in = 8'd0;
        cyc = 0; t_fall = -1; t_idle = -1; got.delete();
        while (cyc < 8000 && (got.size() < 17 || t_idle < 0)) begin
            @(negedge clk);
            cyc++;
            if (cyc < 16) tx_data_in = 8'(cyc);
            if (cyc == 16) begin
                check("burst_level15", tx_level, 15);
                check("burst_ready_at15", tx_ready, 1);
                tx_data_in = 8'd16;
            end
            if (cyc == 17) begin
                tx_valid = 1'b0;
                check("burst_full_ready", tx_ready, 0);
                check("burst_full_level", tx_level, 16);
            end
            if (t_fall < 0 && !tx_data) t_fall = cyc;
            if (t_fall >= 0 && t_idle < 0 && !tx_busy) t_idle = cyc;
            if (rx_valid) got.push_back(rx_data_out);
        end
        rx_ready = 1'b0;
        check("burst_count", got.size(), 17);
        check_range("burst_duration", t_idle - t_fall, 17 * 11 * 32 - 1, 17 * 11 * 32);
        for (int i = 0; i < got.size(); i++) check($sformatf("burst_word%0d", i), got[i], i);

        // Break: line low for 20 bit times gives exactly one 0x00 with frame error.
        rx_drv = 1'b1; loop_en = 1'b0;
        cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        repeat (40) @(negedge clk);
        rx_ready = 1'b1; rx_drv = 1'b0; cnt = 0; bd = 8'hFF; bf = 1'b0;
        for (int c = 0; c < 20 * 32; c++) begin
            @(negedge clk);
            if (rx_valid) begin
                cnt++;
                bd = rx_data_out;
                bf = rx_frame_err;
            end
        end
        check("break_words", cnt, 1);
        check("break_data", bd, 0);
        check("break_ferr", bf, 1);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
        check("break_no_more", rx_level, 0);
        rx_ready = 1'b0;

        // Odd parity with a flipped parity bit, then a clean odd-parity word.
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1;
        drive_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 32);
        wait_rx(100);
        check("par_err_flag", rx_parity_err, 1);
        check("par_err_data", rx_data_out, 8'h3C);
        check("par_err_ferr", rx_frame_err, 0);
        pop_rx();
        w = 8'($urandom);
        drive_frame(w, 1'b1, 1'b1, 1'b0, 1'b0, 32);
        wait_rx(100);
        check("par_ok_flag", rx_parity_err, 0);
        check("par_ok_data", rx_data_out, w);
        pop_rx();

        // Overrun: 17 words with the consumer stalled; the 17th is dropped.
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        expq.delete();
        for (int i = 0; i < 17; i++) begin
            w = 8'($urandom);
            if (i < 16) expq.push_back(w);
            drive_frame(w, 1'b0, 1'b0, 1'b0, 1'b0, 32);
        end
        repeat (4) @(negedge clk);
        check("ovr_level", rx_level, 16);
        check("ovr_flag", rx_overrun, 1);
        rx_overrun_clr = 1'b1;
        @(negedge clk);
        rx_overrun_clr = 1'b0;
        check("ovr_cleared", rx_overrun, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_word%0d", i), rx_data_out, expq[i]);
            pop_rx();
        end
        check("ovr_drained", rx_level, 0);

        // Glitch: a 3-tick low pulse is a false start.
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (96) @(negedge clk);
        check("glitch_level", rx_level, 0);
        check("glitch_valid", rx_valid, 0);
        w = 8'($urandom);
        drive_frame(w, 1'b0, 1'b0, 1'b0, 1'b0, 32);
        wait_rx(100);
        check("glitch_recover", rx_data_out, w);
        pop_rx();

        // Reset in the middle of a TX frame.
        push_tx(8'h00);
        push_tx(8'h00);
        n = 0;
        while (tx_data && n < 100) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        check("mid_tx_low", tx_data, 0);
        check("mid_tx_level", tx_level, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_mid_tx_data", tx_data, 1);
        check("rst_mid_tx_level", tx_level, 0);
        check("rst_mid_tx_busy", tx_busy, 0);
        check("rst_mid_rx_level", rx_level, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", tx_data, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
